led_blink_sched: RTL and testbench

LED_BLINK_SCHED -- requirements
Module: led_blink_sched

---
 rtl/led_blink_sched_pkg.sv | 15 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/led_blink_sched.sv | 152 +++++++++++++++
 tb/tb_led_blink_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_sched_pkg.sv
// Shared definitions for the LED blink scheduler: state encoding and
// default sizing constants.
package led_blink_sched_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GAP   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the one not served last wins. The pointer moves only when the
// grant is actually accepted, so a requester that drops VALID first leaves
// the arbitration order untouched.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Index of the requester served most recently; reset favours requester 0.
  logic last_q;

  // Grant selection, suppressed entirely when arbitration is disabled.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last_q)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  // Pointer update on an accepted grant.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (RST) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// LED blink scheduler. Accepts blink commands from two requesters through a
// round-robin arbiter and plays NUM on/off cycles of HALF clocks each,
// followed by a fixed LED-off gap before the next command may start.
module led_blink_sched
  import led_blink_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [7:0]       REQ0_NUM,
  input  logic [WIDTH-1:0] REQ0_HALF,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [7:0]       REQ1_NUM,
  input  logic [WIDTH-1:0] REQ1_HALF,
  output logic             ULED,
  output logic             BUSY,
  output logic             DONE,
  output logic             OWNER
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic [7:0]       rem_q, rem_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             owner_q, owner_d;
  logic             uled_q;

  logic [1:0]       valid;
  logic [1:0]       gnt;
  logic             arb_en;
  logic             hs;
  logic             sel;
  logic [7:0]       num_sel;
  logic [WIDTH-1:0] half_sel;
  logic [WIDTH-1:0] half_fix;
  logic             phase_last;
  logic             gap_last;

  assign valid  = {REQ1_VALID, REQ0_VALID};
  assign arb_en = (state_q == ST_IDLE) && !RST;
  assign hs     = |(gnt & valid);
  assign sel    = gnt[1];

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .en     (arb_en),
    .req    (valid),
    .accept (hs),
    .gnt    (gnt)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];

  assign num_sel  = sel ? REQ1_NUM  : REQ0_NUM;
  assign half_sel = sel ? REQ1_HALF : REQ0_HALF;
  // A zero half-period would never terminate a phase, so it is treated as one.
  assign half_fix = (half_sel == '0) ? ONE : half_sel;

  // half_q is never zero outside IDLE, so HALF-1 cannot wrap.
  assign phase_last = (phase_q == (half_q - ONE));
  assign gap_last   = (gcnt_q == GAP_LAST);

  // Next-state and datapath update for the blink sequencer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    half_d  = half_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          owner_d = sel;
          half_d  = half_fix;
          rem_d   = num_sel;
          phase_d = '0;
          gcnt_d  = '0;
          state_d = (num_sel != 8'd0) ? ST_ON : ST_GAP;
        end
      end
      ST_ON: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = ST_OFF;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      ST_OFF: begin
        if (phase_last) begin
          phase_d = '0;
          if (rem_q != 8'd0) begin
            rem_d = rem_q - 8'd1;
          end
          state_d = (rem_q <= 8'd1) ? ST_GAP : ST_ON;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          gcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; the LED is registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      half_q  <= '0;
      rem_q   <= 8'd0;
      gcnt_q  <= '0;
      owner_q <= 1'b0;
      uled_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      rem_q   <= rem_d;
      gcnt_q  <= gcnt_d;
      owner_q <= owner_d;
      uled_q  <= (state_d == ST_ON);
    end
  end

  assign ULED  = uled_q;
  assign BUSY  = (state_q != ST_IDLE);
  assign OWNER = owner_q;
  // Reset in the last gap cycle aborts the command, so DONE is masked by RST.
  assign DONE  = (state_q == ST_GAP) && gap_last && !RST;

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed testbench for led_blink_sched: single commands, round-robin
// alternation, zero NUM/HALF, busy arrival, long period and mid-run reset.
module tb_led_blink_sched;

  localparam int GAP_C = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic        REQ0_READY, REQ1_READY;
  logic [7:0]  REQ0_NUM, REQ1_NUM;
  logic [31:0] REQ0_HALF, REQ1_HALF;
  logic        ULED, BUSY, DONE, OWNER;

  int n_tests = 0;
  int n_fail  = 0;

  led_blink_sched #(.WIDTH(32), .GAP(GAP_C)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_NUM   (REQ0_NUM),
    .REQ0_HALF  (REQ0_HALF),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_NUM   (REQ1_NUM),
    .REQ1_HALF  (REQ1_HALF),
    .ULED       (ULED),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .OWNER      (OWNER)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to the drive point of the next cycle (just after the rising edge).
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Present a command and wait (bounded) for its handshake. Returns at the
  // drive point of the first cycle after the handshake.
  task automatic send(input int r, input logic [7:0] num, input logic [31:0] half,
                      input bit hold, output int waited);
    int w;
    bit got;
    w   = 0;
    got = 1'b0;
    if (r == 0) begin
      REQ0_VALID = 1'b1; REQ0_NUM = num; REQ0_HALF = half;
    end else begin
      REQ1_VALID = 1'b1; REQ1_NUM = num; REQ1_HALF = half;
    end
    while (!got && w < 100) begin
      @(negedge CLK);
      if (((r == 0) ? REQ0_READY : REQ1_READY) === 1'b1) begin
        got = 1'b1;
        check($sformatf("other_ready_r%0d", r), (r == 0) ? REQ1_READY : REQ0_READY, 0);
        check($sformatf("busy_at_grant_r%0d", r), BUSY, 0);
      end else begin
        w++;
      end
      next_cycle();
    end
    check($sformatf("grant_seen_r%0d", r), got, 1);
    if (!hold) begin
      if (r == 0) REQ0_VALID = 1'b0;
      else        REQ1_VALID = 1'b0;
    end
    waited = w;
  endtask

  // Check a whole command from the cycle after handshake to DONE inclusive.
  // Optionally raises REQ1_VALID at cycle v1_at. Ends at the drive point of
  // the first cycle after DONE.
  task automatic run_cmd(input string tag, input int num, input int half,
                         input logic owner, input int v1_at);
    int h;
    int on_span;
    int total;
    h       = (half == 0) ? 1 : half;
    on_span = 2 * num * h;
    total   = on_span + GAP_C;
    for (int i = 1; i <= total; i++) begin
      if (i == v1_at) begin
        REQ1_VALID = 1'b1; REQ1_NUM = 8'd1; REQ1_HALF = 32'd1;
      end
      @(negedge CLK);
      check($sformatf("%s_uled@%0d", tag, i), ULED,
            (i <= on_span) && (((i - 1) % (2 * h)) < h));
      check($sformatf("%s_done@%0d", tag, i), DONE, i == total);
      check($sformatf("%s_busy@%0d", tag, i), BUSY, 1);
      check($sformatf("%s_owner@%0d", tag, i), OWNER, owner);
      check($sformatf("%s_ready@%0d", tag, i), REQ0_READY | REQ1_READY, 0);
      next_cycle();
    end
  endtask

  initial begin
    int w;
    int dones;
    int busies;

    RST = 1'b1;
    REQ0_VALID = 1'b1; REQ0_NUM = 8'd1; REQ0_HALF = 32'd1;
    REQ1_VALID = 1'b1; REQ1_NUM = 8'd1; REQ1_HALF = 32'd1;

    // Reset state, with both requesters valid to show READY is held low.
    repeat (2) next_cycle();
    @(negedge CLK);
    check("rst_ready0", REQ0_READY, 0);
    check("rst_ready1", REQ1_READY, 0);
    check("rst_uled",   ULED, 0);
    check("rst_busy",   BUSY, 0);
    check("rst_done",   DONE, 0);
    check("rst_owner",  OWNER, 0);
    next_cycle();
    RST = 1'b0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    next_cycle();

    // Round robin: both held valid, NUM=1 HALF=2 -> req0, req1, req0.
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    send(0, 8'd1, 32'd2, 1'b1, w);
    check("rr_first_wait", w, 0);
    run_cmd("rr_a", 1, 2, 1'b0, 0);
    send(1, 8'd1, 32'd2, 1'b1, w);
    check("rr_second_wait", w, 0);
    run_cmd("rr_b", 1, 2, 1'b1, 0);
    send(0, 8'd1, 32'd2, 1'b0, w);
    check("rr_third_wait", w, 0);
    run_cmd("rr_c", 1, 2, 1'b0, 0);
    REQ1_VALID = 1'b0;
    next_cycle();

    // Single command NUM=3 HALF=4; READY visible right after DONE.
    send(0, 8'd3, 32'd4, 1'b0, w);
    run_cmd("single", 3, 4, 1'b0, 0);
    REQ0_VALID = 1'b1;
    @(negedge CLK);
    check("single_ready_after_done", REQ0_READY, 1);
    REQ0_VALID = 1'b0;
    next_cycle();

    // Zero NUM: LED never lights, DONE 16 cycles after handshake.
    send(0, 8'd0, 32'd5, 1'b0, w);
    run_cmd("num0", 0, 5, 1'b0, 0);

    // Zero HALF treated as one: 1,0,1,0 then gap.
    send(0, 8'd2, 32'd0, 1'b0, w);
    run_cmd("half0", 2, 0, 1'b0, 0);

    // Busy arrival: req1 raises VALID while req0 is in OFF (cycle 5).
    send(0, 8'd2, 32'd3, 1'b0, w);
    run_cmd("busy_arr", 2, 3, 1'b0, 5);
    send(1, 8'd1, 32'd1, 1'b0, w);
    check("busy_arr_wait", w, 0);
    run_cmd("busy_arr_r1", 1, 1, 1'b1, 0);

    // Long period: HALF = 2^32-1 with the phase counter forced near terminal.
    send(0, 8'd1, 32'hFFFF_FFFF, 1'b0, w);
    force dut.phase_q = 32'hFFFF_FFF0;
    #1 release dut.phase_q;
    for (int i = 1; i <= 15; i++) begin
      @(negedge CLK);
      check($sformatf("long_on@%0d", i), ULED, 1);
      next_cycle();
    end
    @(negedge CLK);
    check("long_off_start", ULED, 0);
    check("long_no_wrap", dut.phase_q, 0);
    force dut.phase_q = 32'hFFFF_FFF0;
    #1 release dut.phase_q;
    next_cycle();
    for (int i = 17; i <= 46; i++) begin
      @(negedge CLK);
      check($sformatf("long_uled@%0d", i), ULED, 0);
      check($sformatf("long_done@%0d", i), DONE, i == 46);
      next_cycle();
    end
    @(negedge CLK);
    check("long_idle", BUSY, 0);
    next_cycle();

    // Reset during the second ON phase of NUM=3 HALF=4.
    send(0, 8'd3, 32'd4, 1'b0, w);
    for (int i = 1; i <= 9; i++) begin
      @(negedge CLK);
      check($sformatf("abort_uled@%0d", i), ULED, ((i - 1) % 8) < 4);
      next_cycle();
    end
    RST = 1'b1;
    REQ0_VALID = 1'b1;
    @(negedge CLK);
    check("abort_ready_in_rst", REQ0_READY, 0);
    check("abort_done_in_rst", DONE, 0);
    next_cycle();
    @(negedge CLK);
    check("abort_uled", ULED, 0);
    check("abort_busy", BUSY, 0);
    check("abort_ready_rst2", REQ0_READY, 0);
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check("abort_ready_after", REQ0_READY, 1);
    REQ0_VALID = 1'b0;
    dones  = 0;
    busies = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
      if (BUSY === 1'b1) busies++;
    end
    check("abort_no_done", dones, 0);
    check("abort_drop_no_effect", busies, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
